// File: rtl/bk_sd_xfer.sv
// -----------------------------------------------------------------------------
// bk_sd_xfer
//
// Moves the cartridge backup (battery save) RAM to and from the SD save image
// through the HPS sector interface. It handles:
//   * loading the image after a ROM download;
//   * OSD-requested load and save;
//   * tracking whether the RAM differs from the image;
//   * an idle-timed autosave;
//   * aborting when the HPS never acknowledges a sector request.
//
// Ports
//   clk_sys      in   system clock
//   reset        in   synchronous, active-low power-on reset
//   ram_mask     in   backup RAM size-1 (0 = no backup RAM)
//   rom_loading  in   ROM download in progress
//   img_valid    in   save image mounted, non-empty and writable
//   load_req     in   OSD load request level (acts on rising edge)
//   save_req     in   OSD save request level (acts on rising edge)
//   autosave_en  in   enables the idle autosave
//   ram_wr       in   one-cycle strobe per CPU write to backup RAM
//   sd_ack       in   HPS sector transfer acknowledge
//   sd_lba       out  sector number of the current request
//   sd_rd        out  sector read request
//   sd_wr        out  sector write request
//   bk_ena       out  backup feature available
//   bk_loading   out  load in progress (holds the core in reset)
//   bk_busy      out  any transfer in progress
//   dirty        out  RAM differs from the SD image
//   err          out  one-cycle pulse when a request times out
// -----------------------------------------------------------------------------
module bk_sd_xfer #(
    parameter int          MASK_W       = 24,
    parameter int          SECTOR_BITS  = 9,
    parameter logic [31:0] AUTOSAVE_CYC = 32'd42954540,
    parameter logic [31:0] ACK_TIMEOUT  = 32'd4000000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [MASK_W-1:0] ram_mask,
    input  logic              rom_loading,
    input  logic              img_valid,
    input  logic              load_req,
    input  logic              save_req,
    input  logic              autosave_en,
    input  logic              ram_wr,
    input  logic              sd_ack,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    output logic              bk_ena,
    output logic              bk_loading,
    output logic              bk_busy,
    output logic              dirty,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER
    } state_t;

    state_t      state_q;
    logic        mode_load_q;    // 1 = current transfer is a load
    logic        wr_during_q;    // RAM was written while the current save ran
    logic [31:0] to_cnt_q;       // cycles spent waiting for sd_ack
    logic [31:0] as_cnt_q;       // idle cycles since the last RAM write
    logic        old_load_q;
    logic        old_save_q;
    logic        old_ack_q;
    logic        old_dl_q;

    logic [31:0] mask_ext;
    logic [31:0] last_sec;
    logic        load_edge;
    logic        save_edge;
    logic        ack_rise;
    logic        ack_fall;
    logic        dl_rise;
    logic        dl_fall;
    logic        is_idle;
    logic        as_cond;
    logic        as_fire;
    logic        start_load;
    logic        start_save;
    logic        abort;
    logic        dirty_set;

    assign mask_ext  = 32'(ram_mask);
    assign last_sec  = mask_ext >> SECTOR_BITS;

    // OSD requests are only honoured while the feature is available; the
    // history register holds the gated level so enabling bk_ena while a
    // request is already high counts as an edge.
    assign load_edge = load_req & bk_ena & ~old_load_q;
    assign save_edge = save_req & bk_ena & ~old_save_q;
    assign ack_rise  = sd_ack & ~old_ack_q;
    assign ack_fall  = ~sd_ack & old_ack_q;
    assign dl_rise   = rom_loading & ~old_dl_q;
    assign dl_fall   = ~rom_loading & old_dl_q;

    assign is_idle   = (state_q == ST_IDLE);

    // A fresh RAM write restarts the idle window, so the autosave fires only
    // after AUTOSAVE_CYC quiet cycles.
    assign as_cond   = is_idle & dirty & autosave_en & bk_ena & ~rom_loading;
    assign as_fire   = as_cond & ~ram_wr & (as_cnt_q == AUTOSAVE_CYC - 32'd1);

    // Load sources outrank save sources; a save edge coinciding with a load
    // start is simply lost.
    assign start_load = is_idle & ((dl_fall & bk_ena) | load_edge);
    assign start_save = is_idle & ~start_load & (save_edge | as_fire);

    // A new ROM download invalidates whatever transfer was running.
    assign abort      = dl_rise & ~is_idle;

    assign dirty_set  = ram_wr & bk_ena & ~bk_loading;

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mode_load_q <= 1'b0;
            wr_during_q <= 1'b0;
            to_cnt_q    <= '0;
            as_cnt_q    <= '0;
            old_load_q  <= 1'b0;
            old_save_q  <= 1'b0;
            old_ack_q   <= 1'b0;
            old_dl_q    <= 1'b0;
            sd_lba      <= '0;
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            bk_ena      <= 1'b0;
            bk_loading  <= 1'b0;
            bk_busy     <= 1'b0;
            dirty       <= 1'b0;
            err         <= 1'b0;
        end else begin
            old_load_q <= load_req & bk_ena;
            old_save_q <= save_req & bk_ena;
            old_ack_q  <= sd_ack;
            old_dl_q   <= rom_loading;
            err        <= 1'b0;

            if (dl_rise) begin
                bk_ena <= 1'b0;
            end else if (rom_loading & img_valid) begin
                bk_ena <= (ram_mask != '0);
            end

            if (ram_wr & bk_busy & ~mode_load_q) begin
                wr_during_q <= 1'b1;
            end

            if (!as_cond || ram_wr || start_load || start_save) begin
                as_cnt_q <= '0;
            end else begin
                as_cnt_q <= as_cnt_q + 32'd1;
            end

            if (abort) begin
                sd_rd      <= 1'b0;
                sd_wr      <= 1'b0;
                bk_busy    <= 1'b0;
                bk_loading <= 1'b0;
                dirty      <= 1'b0;
                state_q    <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_load || start_save) begin
                            sd_lba      <= '0;
                            mode_load_q <= start_load;
                            bk_busy     <= 1'b1;
                            bk_loading  <= start_load;
                            sd_rd       <= start_load;
                            sd_wr       <= ~start_load;
                            to_cnt_q    <= '0;
                            state_q     <= ST_REQ;
                            if (start_save) begin
                                wr_during_q <= 1'b0;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (ack_rise) begin
                            sd_rd   <= 1'b0;
                            sd_wr   <= 1'b0;
                            state_q <= ST_XFER;
                        end else if (to_cnt_q == ACK_TIMEOUT - 32'd1) begin
                            sd_rd      <= 1'b0;
                            sd_wr      <= 1'b0;
                            err        <= 1'b1;
                            bk_loading <= 1'b0;
                            bk_busy    <= 1'b0;
                            state_q    <= ST_IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + 32'd1;
                        end
                    end
                    ST_XFER: begin
                        if (ack_fall) begin
                            if (sd_lba >= last_sec) begin
                                bk_loading <= 1'b0;
                                bk_busy    <= 1'b0;
                                state_q    <= ST_IDLE;
                                // A save only brings the image up to date if
                                // the RAM was not touched while it ran.
                                if (mode_load_q || !wr_during_q) begin
                                    dirty <= 1'b0;
                                end
                            end else begin
                                sd_lba   <= sd_lba + 32'd1;
                                sd_rd    <= mode_load_q;
                                sd_wr    <= ~mode_load_q;
                                to_cnt_q <= '0;
                                state_q  <= ST_REQ;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end

            // A write in the same cycle as a clear must leave dirty set.
            if (dirty_set) begin
                dirty <= 1'b1;
            end
        end
    end

endmodule
